// File: rtl/led_step_checker.sv
// ---------------------------------------------------------------------------
// led_step_checker
//
// Receive-side monitor for an 8-bit stepping LED counter bus. It samples
// LED_IN and checks two things at every change of the sampled value:
//   - the new value is the previous value + 1 (mod 256, so 255 -> 0 is legal)
//   - the interval since the previous change is within [STEP-TOL, STEP+TOL]
// A small INIT / ACQ / LOCK state machine builds confidence before errors are
// reported. Once locked, a failed check, or a stall longer than STEP+TOL
// cycles, raises an error.
//
// Parameters:
//   STEP  expected clock cycles between LED increments
//   TOL   allowed deviation in cycles (TOL < STEP)
//
// Ports:
//   CLK         in   1   clock, rising edge
//   RST         in   1   synchronous active-high reset
//   LED_IN      in   8   observed LED counter value
//   LOCKED      out  1   high while the stream is verified in-step
//   ERR         out  1   one-cycle pulse per detected error
//   ERR_COUNT   out  8   errors since reset, saturates at 255
//   PERIOD      out  32  last measured change interval in cycles
//   LAST_VALUE  out  8   value captured at the last change
//
// Build option:
//   LED_STEP_CHECKER_SYNC_EN  when defined, LED_IN passes through a 2-flop
//                             synchronizer first (all latencies +2 cycles).
// ---------------------------------------------------------------------------
module led_step_checker #(
    parameter int STEP = 10,
    parameter int TOL  = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  LED_IN,
    output logic        LOCKED,
    output logic        ERR,
    output logic [7:0]  ERR_COUNT,
    output logic [31:0] PERIOD,
    output logic [7:0]  LAST_VALUE
);

    localparam logic [31:0] INTERVAL_MIN = 32'(STEP - TOL);
    localparam logic [31:0] INTERVAL_MAX = 32'(STEP + TOL);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  w_led_src;
    logic [7:0]  r_in_q;
    logic [7:0]  r_prev_q;
    logic [31:0] r_cnt;

    logic        r_err;
    logic [7:0]  r_err_count;
    logic [31:0] r_period;
    logic [7:0]  r_last_value;

    logic        w_change;
    logic        w_value_ok;
    logic        w_interval_ok;
    logic        w_checks_ok;
    logic        w_timeout;
    logic        w_err_event;
    logic        w_load_period;
    logic        w_load_value;
    logic        w_locked;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef LED_STEP_CHECKER_SYNC_EN
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;

    // Two-flop synchronizer for an LED_IN driven from another clock domain
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 8'd0;
            r_sync2 <= 8'd0;
        end else begin
            r_sync1 <= LED_IN;
            r_sync2 <= r_sync1;
        end
    end

    assign w_led_src = r_sync2;
`else
    assign w_led_src = LED_IN;
`endif

    // A change is seen one cycle after the new value lands in r_in_q, so the
    // interval counter value at that moment equals the spacing of changes.
    assign w_change      = (r_in_q != r_prev_q);
    assign w_value_ok    = (r_in_q == 8'(r_prev_q + 8'd1));
    assign w_interval_ok = (r_cnt >= INTERVAL_MIN) && (r_cnt <= INTERVAL_MAX);
    assign w_checks_ok   = w_value_ok && w_interval_ok;
    // A change in the same cycle always wins over the stall timeout
    assign w_timeout     = (r_state == S_LOCK) && !w_change && (r_cnt == INTERVAL_MAX);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_INIT: begin
                if (w_change) begin
                    w_state_next = S_ACQ;
                end
            end
            S_ACQ: begin
                if (w_change && w_checks_ok) begin
                    w_state_next = S_LOCK;
                end
            end
            S_LOCK: begin
                if (w_change) begin
                    if (!w_checks_ok) begin
                        w_state_next = S_ACQ;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_INIT;
                end
            end
            default: begin
                w_state_next = S_INIT;
            end
        endcase
    end

    // Output decode
    always_comb begin
        w_err_event   = 1'b0;
        w_load_period = 1'b0;
        w_load_value  = 1'b0;
        w_locked      = 1'b0;
        case (r_state)
            S_INIT: begin
                w_load_value = w_change;
            end
            S_ACQ: begin
                w_load_value  = w_change;
                w_load_period = w_change;
            end
            S_LOCK: begin
                w_locked      = 1'b1;
                w_load_value  = w_change;
                w_load_period = w_change;
                w_err_event   = (w_change && !w_checks_ok) || w_timeout;
            end
            default: begin
                w_locked = 1'b0;
            end
        endcase
    end

    // Sampling, interval counter and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_in_q       <= 8'd0;
            r_prev_q     <= 8'd0;
            r_cnt        <= 32'd0;
            r_err        <= 1'b0;
            r_err_count  <= 8'd0;
            r_period     <= 32'd0;
            r_last_value <= 8'd0;
        end else begin
            r_in_q <= w_led_src;
            if (w_change) begin
                r_prev_q <= r_in_q;
                r_cnt    <= 32'd1;
            end else begin
                r_cnt <= sat_inc32(r_cnt);
            end
            r_err <= w_err_event;
            if (w_err_event) begin
                r_err_count <= sat_inc8(r_err_count);
            end
            if (w_load_period) begin
                r_period <= r_cnt;
            end
            if (w_load_value) begin
                r_last_value <= r_in_q;
            end
        end
    end

    assign LOCKED     = w_locked;
    assign ERR        = r_err;
    assign ERR_COUNT  = r_err_count;
    assign PERIOD     = r_period;
    assign LAST_VALUE = r_last_value;

endmodule

// File: tb/tb_led_step_checker.sv
// ---------------------------------------------------------------------------
// tb_led_step_checker
//
// Drives LED_IN change sequences with chosen spacing into led_step_checker
// (STEP=10, TOL=1). Each applied change pushes its expected outputs, together
// with the cycle they become visible, into a scoreboard queue; a monitor pops
// and compares them. Scenario tasks add inline checks for timing-specific
// behaviour (reset, stall timeout, saturation).
// ---------------------------------------------------------------------------
module tb_led_step_checker;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  LED_IN = 8'h5A;
    logic        LOCKED;
    logic        ERR;
    logic [7:0]  ERR_COUNT;
    logic [31:0] PERIOD;
    logic [7:0]  LAST_VALUE;

    int checks   = 0;
    int errors   = 0;
    int err_seen = 0;
    int cyc      = 0;
    int exp_cnt  = 0;

    typedef struct {
        int          due;
        logic [7:0]  v;
        logic        err;
        logic        locked;
        logic [7:0]  cnt;
        logic [31:0] period;
        logic [7:0]  last;
    } exp_t;

    exp_t sb[$];

    led_step_checker #(.STEP(10), .TOL(1)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .LED_IN     (LED_IN),
        .LOCKED     (LOCKED),
        .ERR        (ERR),
        .ERR_COUNT  (ERR_COUNT),
        .PERIOD     (PERIOD),
        .LAST_VALUE (LAST_VALUE)
    );

    always #5 CLK = ~CLK;

    // Counts every cycle in which ERR is high
    always @(negedge CLK) begin
        if (ERR === 1'b1) err_seen++;
    end

    // Scoreboard monitor: compares outputs when an expected entry falls due
    always @(posedge CLK) begin
        exp_t e;
        cyc++;
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            if (ERR !== e.err) begin
                errors++;
                $display("FAIL sb_err v=%0d: got %b want %b", e.v, ERR, e.err);
            end
            checks++;
            if (LOCKED !== e.locked) begin
                errors++;
                $display("FAIL sb_locked v=%0d: got %b want %b", e.v, LOCKED, e.locked);
            end
            checks++;
            if (ERR_COUNT !== e.cnt) begin
                errors++;
                $display("FAIL sb_err_count v=%0d: got %0d want %0d", e.v, ERR_COUNT, e.cnt);
            end
            checks++;
            if (PERIOD !== e.period) begin
                errors++;
                $display("FAIL sb_period v=%0d: got %0d want %0d", e.v, PERIOD, e.period);
            end
            checks++;
            if (LAST_VALUE !== e.last) begin
                errors++;
                $display("FAIL sb_last_value v=%0d: got %0d want %0d", e.v, LAST_VALUE, e.last);
            end
        end
    end

    // Waits wait_edges edges, applies v just after an edge and records the
    // outputs expected two edges later. Returns just after that second edge.
    // A change applied wait_edges+2 cycles after the previous one gives an
    // interval of wait_edges+2.
    task automatic step(input logic [7:0] v, input int wait_edges,
                        input logic e_err, input logic e_lock,
                        input logic [31:0] e_per, input logic [7:0] e_last);
        exp_t e;
        repeat (wait_edges) @(posedge CLK);
        #1;
        LED_IN   = v;
        e.due    = cyc + 2;
        e.v      = v;
        e.err    = e_err;
        e.locked = e_lock;
        e.cnt    = 8'(exp_cnt);
        e.period = e_per;
        e.last   = e_last;
        sb.push_back(e);
        @(posedge CLK);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST    = 1'b1;
        LED_IN = 8'h5A;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (LOCKED !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", LOCKED); end
        checks++;
        if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ERR); end
        checks++;
        if (ERR_COUNT !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", ERR_COUNT); end
        checks++;
        if (PERIOD !== 32'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", PERIOD); end
        checks++;
        if (LAST_VALUE !== 8'd0) begin errors++; $display("FAIL reset_last_value: got %0d want 0", LAST_VALUE); end
        LED_IN = 8'd0;
        RST    = 1'b0;
    endtask

    task automatic test_ideal();
        int e0;
        e0 = err_seen;
        step(8'd1, 8, 1'b0, 1'b0, 32'd0, 8'd1);   // INIT -> ACQ, no PERIOD yet
        step(8'd2, 8, 1'b0, 1'b1, 32'd10, 8'd2);  // locks on 1->2
        for (int v = 3; v <= 301; v++) begin
            step(8'(v), 8, 1'b0, 1'b1, 32'd10, 8'(v));
        end
        checks++;
        if (err_seen - e0 !== 0) begin
            errors++;
            $display("FAIL ideal_no_err: got %0d pulses want 0", err_seen - e0);
        end
    endtask

    task automatic test_wrap_tol();
        int e0;
        for (int v = 46; v <= 254; v++) begin
            step(8'(v), 8, 1'b0, 1'b1, 32'd10, 8'(v));
        end
        step(8'd255, 7, 1'b0, 1'b1, 32'd9, 8'd255);
        step(8'd0, 9, 1'b0, 1'b1, 32'd11, 8'd0);
        // Interval 12: the stall timeout fires first, then the late change
        // is taken as a fresh reference in INIT (PERIOD keeps 11).
        e0 = err_seen;
        exp_cnt = 1;
        step(8'd1, 10, 1'b0, 1'b0, 32'd11, 8'd1);
        checks++;
        if (err_seen - e0 !== 1) begin
            errors++;
            $display("FAIL interval12_pulse: got %0d pulses want 1", err_seen - e0);
        end
        step(8'd2, 8, 1'b0, 1'b1, 32'd10, 8'd2);
    endtask

    task automatic test_skip();
        int e0;
        step(8'd3, 8, 1'b0, 1'b1, 32'd10, 8'd3);
        step(8'd4, 8, 1'b0, 1'b1, 32'd10, 8'd4);
        step(8'd5, 8, 1'b0, 1'b1, 32'd10, 8'd5);
        e0 = err_seen;
        exp_cnt = 2;
        step(8'd7, 8, 1'b1, 1'b0, 32'd10, 8'd7);
        step(8'd8, 8, 1'b0, 1'b1, 32'd10, 8'd8);
        checks++;
        if (err_seen - e0 !== 1) begin
            errors++;
            $display("FAIL skip_single_pulse: got %0d pulses want 1", err_seen - e0);
        end
    endtask

    task automatic test_stall();
        step(8'd9, 8, 1'b0, 1'b1, 32'd10, 8'd9);
        repeat (10) @(posedge CLK);
        #1;
        checks++;
        if (ERR !== 1'b0 || LOCKED !== 1'b1) begin
            errors++;
            $display("FAIL stall_early: got err=%b locked=%b want err=0 locked=1", ERR, LOCKED);
        end
        exp_cnt = 3;
        @(posedge CLK);
        #1;
        checks++;
        if (ERR !== 1'b1) begin errors++; $display("FAIL stall_err: got %b want 1", ERR); end
        checks++;
        if (LOCKED !== 1'b0) begin errors++; $display("FAIL stall_locked: got %b want 0", LOCKED); end
        checks++;
        if (ERR_COUNT !== 8'd3) begin errors++; $display("FAIL stall_err_count: got %0d want 3", ERR_COUNT); end
        checks++;
        if (PERIOD !== 32'd10) begin errors++; $display("FAIL stall_period: got %0d want 10", PERIOD); end
        @(posedge CLK);
        #1;
        checks++;
        if (ERR !== 1'b0) begin errors++; $display("FAIL stall_err_width: got %b want 0", ERR); end
        // 20 cycles after the last change: INIT -> ACQ, then relock
        step(8'd11, 6, 1'b0, 1'b0, 32'd10, 8'd11);
        step(8'd12, 8, 1'b0, 1'b1, 32'd10, 8'd12);
    endtask

    task automatic test_midreset_sat();
        logic [7:0] cur;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (LOCKED !== 1'b0 || ERR !== 1'b0 || ERR_COUNT !== 8'd0 ||
            PERIOD !== 32'd0 || LAST_VALUE !== 8'd0) begin
            errors++;
            $display("FAIL midreset_clear: got locked=%b err=%b cnt=%0d period=%0d last=%0d want all 0",
                     LOCKED, ERR, ERR_COUNT, PERIOD, LAST_VALUE);
        end
        LED_IN  = 8'd0;
        RST     = 1'b0;
        exp_cnt = 0;
        step(8'd1, 8, 1'b0, 1'b0, 32'd0, 8'd1);
        step(8'd2, 8, 1'b0, 1'b1, 32'd10, 8'd2);
        cur = 8'd2;
        for (int i = 1; i <= 300; i++) begin
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            cur = 8'(cur + 8'd2);
            step(cur, 8, 1'b1, 1'b0, 32'd10, cur);
            cur = 8'(cur + 8'd1);
            step(cur, 8, 1'b0, 1'b1, 32'd10, cur);
        end
        checks++;
        if (ERR_COUNT !== 8'd255) begin
            errors++;
            $display("FAIL saturation: got %0d want 255", ERR_COUNT);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_wrap_tol();
        test_skip();
        test_stall();
        test_midreset_sat();
        repeat (4) @(posedge CLK);
        #2;
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
